data_mem_arbiter: RTL and testbench

//  Shares the single byte-addressed, 64-bit-word data memory between two requesters:

---
 rtl/data_mem_arbiter_pkg.sv | 18 +
 rtl/data_mem_arbiter_rr.sv | 21 ++
 rtl/data_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM encodings,
// default geometry and requester port ids.
package dmem_pkg;

    localparam int ADDR_W_DEF    = 64;
    localparam int DATA_W_DEF    = 64;
    localparam int MEM_BYTES_DEF = 64;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie goes to the port that did not win the previous tie.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant_id,
    output logic       o_any_req
);

    always_comb begin
        o_any_req  = |i_req;
        o_grant_id = PORT0;
        if (&i_req)
            o_grant_id = ~i_last_grant;
        else if (i_req[1])
            o_grant_id = PORT1;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one byte-addressed data memory between the load/store unit (port 0)
// and the debug/loader (port 1) as fixed IDLE/ACCESS/DONE transactions.
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_r0_req,
    input  logic              i_r0_we,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [DATA_W-1:0] i_r0_wdata,
    output logic              o_r0_gnt,
    output logic              o_r0_done,
    output logic [DATA_W-1:0] o_r0_rdata,
    output logic              o_r0_err,

    input  logic              i_r1_req,
    input  logic              i_r1_we,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [DATA_W-1:0] i_r1_wdata,
    output logic              o_r1_gnt,
    output logic              o_r1_done,
    output logic [DATA_W-1:0] o_r1_rdata,
    output logic              o_r1_err,

    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_write,
    output logic              o_mem_read,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    // Highest start address whose whole word still fits in memory.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - DATA_W / 8);

    state_t              r_state;
    state_t              w_next;
    logic                r_last_grant;
    logic                r_sel;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_grant_id;
    logic                w_any_req;
    logic                w_in_range;
    logic                w_latch;
    logic                w_capture;
    logic [DATA_W-1:0]   w_cap_data;

    rr_arbiter2 u_arb (
        .i_req        ({i_r1_req, i_r0_req}),
        .i_last_grant (r_last_grant),
        .o_grant_id   (w_grant_id),
        .o_any_req    (w_any_req)
    );

    assign w_in_range = (r_addr <= LAST_ADDR);
    assign w_latch    = (r_state == ST_IDLE) && w_any_req;
    // Loads capture memory data; any out-of-range access clears the port's rdata.
    assign w_capture  = (r_state == ST_ACCESS) && (!r_we || !w_in_range);
    assign w_cap_data = w_in_range ? i_mem_rdata : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_next = ST_ACCESS;
            ST_ACCESS: w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= PORT1;
            r_sel        <= PORT0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if (w_latch) begin
                r_sel   <= w_grant_id;
                r_we    <= (w_grant_id == PORT1) ? i_r1_we    : i_r0_we;
                r_addr  <= (w_grant_id == PORT1) ? i_r1_addr  : i_r0_addr;
                r_wdata <= (w_grant_id == PORT1) ? i_r1_wdata : i_r0_wdata;
                if (i_r0_req && i_r1_req)
                    r_last_grant <= w_grant_id;
            end
            if (w_capture) begin
                if (r_sel == PORT1)
                    r_rdata1 <= w_cap_data;
                else
                    r_rdata0 <= w_cap_data;
            end
        end
    end

    always_comb begin
        o_r0_gnt    = 1'b0;
        o_r1_gnt    = 1'b0;
        o_r0_done   = 1'b0;
        o_r1_done   = 1'b0;
        o_r0_err    = 1'b0;
        o_r1_err    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                o_r0_gnt = (r_sel == PORT0);
                o_r1_gnt = (r_sel == PORT1);
                if (w_in_range) begin
                    o_mem_addr  = r_addr;
                    o_mem_wdata = r_wdata;
                    o_mem_read  = ~r_we;
                    // A store caught by reset in this cycle must not commit.
                    o_mem_write = r_we & ~i_reset;
                end
            end
            ST_DONE: begin
                o_r0_done = (r_sel == PORT0);
                o_r1_done = (r_sel == PORT1);
                o_r0_err  = (r_sel == PORT0) && !w_in_range;
                o_r1_err  = (r_sel == PORT1) && !w_in_range;
            end
            default: ;
        endcase
    end

    assign o_r0_rdata = r_rdata0;
    assign o_r1_rdata = r_rdata1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a directed vector table, hand-written tie/reset
// sequences, then random traffic against a transaction-level reference model.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_init = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [63:0] r0_addr = '0, r0_wdata = '0;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [63:0] r1_addr = '0, r1_wdata = '0;
    logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
    logic [63:0] r0_rdata, r1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    logic [7:0]  mem [64];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .i_clk(clk), .i_reset(reset),
        .i_r0_req(r0_req), .i_r0_we(r0_we), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
        .o_r0_gnt(r0_gnt), .o_r0_done(r0_done), .o_r0_rdata(r0_rdata), .o_r0_err(r0_err),
        .i_r1_req(r1_req), .i_r1_we(r1_we), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
        .o_r1_gnt(r1_gnt), .o_r1_done(r1_done), .o_r1_rdata(r1_rdata), .o_r1_err(r1_err),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_write(mem_write),
        .o_mem_read(mem_read), .i_mem_rdata(mem_rdata)
    );

    // Memory: byte i initialised to i, combinational little-endian read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
        end else if (mem_write) begin
            for (int b = 0; b < 8; b++)
                if (mem_addr <= 64'(63 - b)) mem[6'(mem_addr[5:0] + 6'(b))] <= mem_wdata[8*b +: 8];
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int b = 0; b < 8; b++)
            if (mem_addr <= 64'(63 - b)) mem_rdata[8*b +: 8] = mem[6'(mem_addr[5:0] + 6'(b))];
    end

    function automatic logic [63:0] mem_word(input int a);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = mem[a + b];
        return w;
    endfunction

    function automatic logic [63:0] ctl();
        return {56'd0, r1_gnt, r0_gnt, r1_done, r0_done, r1_err, r0_err, mem_read, mem_write};
    endfunction

    function automatic logic [63:0] ectl(input logic [1:0] g, input logic [1:0] d,
                                         input logic [1:0] e, input logic rd, input logic wr);
        return {56'd0, g, d, e, rd, wr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic req, input logic we,
                         input logic [63:0] a, input logic [63:0] d);
        if (p) begin
            r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
        end else begin
            r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_init = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) step();
        reset = 1'b0; mem_init = 1'b0;
    endtask

    typedef struct {
        logic        p;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        err;
        logic [63:0] rdata;
    } vec_t;

    vec_t tv [12];

    // One isolated transaction, checked cycle by cycle.
    task automatic do_txn(input vec_t v);
        logic [1:0] g;
        g = v.p ? 2'b10 : 2'b01;
        drive(v.p, 1'b1, v.we, v.addr, v.wdata);
        step();
        chk("gnt_ctl", ctl(), ectl(g, 2'b00, 2'b00, !v.err && !v.we, !v.err && v.we));
        chk("gnt_addr", mem_addr, v.err ? 64'd0 : v.addr);
        step();
        chk("done_ctl", ctl(), ectl(2'b00, g, v.err ? g : 2'b00, 1'b0, 1'b0));
        chk("done_rdata", v.p ? r1_rdata : r0_rdata, v.rdata);
        drive(v.p, 1'b0, 1'b0, '0, '0);
        step();
        chk("idle_ctl", ctl(), 64'd0);
    endtask

    // Reference model state for the random phase.
    logic        a_req [2];
    logic        a_we [2];
    logic [63:0] a_addr [2];
    logic [63:0] a_wdata [2];
    logic [63:0] em_rd [2];
    logic [7:0]  rm [64];
    logic        m_last, cp, c_we, c_ok, eg, ed;
    logic [63:0] c_addr, c_wdata, c_ld;
    logic [1:0]  oh;
    int          lat_at, free_at;
    int          gp [4];
    int          gc [4];
    int          ng;

    task automatic new_op(input int p);
        int sel;
        sel = int'($urandom % 8);
        a_we[p] = 1'($urandom % 2);
        if (sel < 6)       a_addr[p] = 64'($urandom_range(0, 56));
        else if (sel == 6) a_addr[p] = 64'($urandom_range(57, 63));
        else               a_addr[p] = {$urandom, $urandom} | 64'h1_0000_0000;
        a_wdata[p] = {$urandom, $urandom};
        a_req[p] = 1'b1;
    endtask

    initial begin
        tv[0]  = '{1'b0, 1'b1, 64'd8,  64'h1122334455667788, 1'b0, 64'h0};
        tv[1]  = '{1'b0, 1'b0, 64'd8,  64'h0,                1'b0, 64'h1122334455667788};
        tv[2]  = '{1'b1, 1'b0, 64'd0,  64'h0,                1'b0, 64'h0706050403020100};
        tv[3]  = '{1'b0, 1'b0, 64'd1,  64'h0,                1'b0, 64'h8807060504030201};
        tv[4]  = '{1'b1, 1'b0, 64'd57, 64'h0,                1'b1, 64'h0};
        tv[5]  = '{1'b1, 1'b0, 64'h1_0000_0000, 64'h0,       1'b1, 64'h0};
        tv[6]  = '{1'b0, 1'b1, 64'd0,  64'hA5A55A5ADEADBEEF, 1'b0, 64'h8807060504030201};
        tv[7]  = '{1'b0, 1'b0, 64'd0,  64'h0,                1'b0, 64'hA5A55A5ADEADBEEF};
        tv[8]  = '{1'b0, 1'b1, 64'd60, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0};
        tv[9]  = '{1'b1, 1'b0, 64'd56, 64'h0,                1'b0, 64'h3F3E3D3C3B3A3938};
        tv[10] = '{1'b1, 1'b1, 64'd56, 64'h0123456789ABCDEF, 1'b0, 64'h3F3E3D3C3B3A3938};
        tv[11] = '{1'b1, 1'b0, 64'd56, 64'h0,                1'b0, 64'h0123456789ABCDEF};

        do_reset();
        chk("reset_ctl", ctl(), 64'd0);
        chk("reset_maddr", mem_addr, 64'd0);
        chk("reset_mwdata", mem_wdata, 64'd0);
        chk("reset_rdata0", r0_rdata, 64'd0);
        chk("reset_rdata1", r1_rdata, 64'd0);

        for (int i = 0; i < 12; i++) begin
            do_txn(tv[i]);
            if (i == 0) begin
                chk("byte8", 64'(mem[8]), 64'h88);
                chk("byte15", 64'(mem[15]), 64'h11);
            end
        end

        // Simultaneous requests after reset: port 0 first, port 1 next.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 64'd0, '0);
        drive(1'b1, 1'b1, 1'b0, 64'd16, '0);
        step();
        chk("tie_gnt0", ctl(), ectl(2'b01, 2'b00, 2'b00, 1'b1, 1'b0));
        step();
        chk("tie_done0", ctl(), ectl(2'b00, 2'b01, 2'b00, 1'b0, 1'b0));
        chk("tie_rdata0", r0_rdata, 64'h0706050403020100);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        chk("tie_idle", ctl(), 64'd0);
        step();
        chk("tie_gnt1", ctl(), ectl(2'b10, 2'b00, 2'b00, 1'b1, 1'b0));
        chk("tie_addr1", mem_addr, 64'd16);
        step();
        chk("tie_done1", ctl(), ectl(2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
        chk("tie_rdata1", r1_rdata, 64'h1716151413121110);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // Both requesters held continuously: grants alternate every 3 cycles.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 64'd0, '0);
        drive(1'b1, 1'b1, 1'b0, 64'd8, '0);
        ng = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            step();
            if (r0_gnt || r1_gnt) begin
                gp[ng] = int'(r1_gnt);
                gc[ng] = c;
                ng++;
            end
            if (r0_done) drive(1'b0, 1'b1, 1'b0, 64'(8 * (c % 7)), '0);
            if (r1_done) drive(1'b1, 1'b1, 1'b0, 64'(8 * (c % 7)), '0);
        end
        chk("alt_count", 64'(ng), 64'd4);
        for (int i = 0; i < ng; i++) begin
            chk("alt_port", 64'(gp[i]), 64'(i % 2));
            if (i > 0) chk("alt_gap", 64'(gc[i] - gc[i-1]), 64'd3);
        end

        // Reset while a store is in ACCESS: no commit, no done, tie state restored.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 64'd24, 64'hDEADBEEFCAFEF00D);
        drive(1'b1, 1'b1, 1'b0, 64'd32, '0);
        step();
        chk("rst_gnt", ctl(), ectl(2'b01, 2'b00, 2'b00, 1'b0, 1'b1));
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        #1;
        chk("rst_wr_block", 64'(mem_write), 64'd0);
        step();
        reset = 1'b0;
        chk("rst_ctl", ctl(), 64'd0);
        chk("rst_maddr", mem_addr, 64'd0);
        chk("rst_rdata0", r0_rdata, 64'd0);
        chk("rst_mem", mem_word(24), 64'h1F1E1D1C1B1A1918);
        drive(1'b0, 1'b1, 1'b0, 64'd0, '0);
        drive(1'b1, 1'b1, 1'b0, 64'd8, '0);
        step();
        chk("rst_next_tie", ctl(), ectl(2'b01, 2'b00, 2'b00, 1'b1, 1'b0));

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 64; i++) rm[i] = 8'(i);
        for (int p = 0; p < 2; p++) begin
            a_req[p] = 1'b0; a_we[p] = 1'b0; a_addr[p] = '0; a_wdata[p] = '0; em_rd[p] = '0;
        end
        m_last = 1'b1; cp = 1'b0; c_we = 1'b0; c_ok = 1'b1; c_addr = '0; c_wdata = '0; c_ld = '0;
        lat_at = -10; free_at = 0;
        for (int k = 1; k <= 800; k++) begin
            step();
            if (k >= free_at && (a_req[0] || a_req[1])) begin
                if (a_req[0] && a_req[1]) begin
                    cp = ~m_last;
                    m_last = cp;
                end else begin
                    cp = a_req[1];
                end
                c_we = a_we[cp]; c_addr = a_addr[cp]; c_wdata = a_wdata[cp];
                c_ok = (c_addr <= 64'd56);
                c_ld = '0;
                if (c_ok) begin
                    for (int b = 0; b < 8; b++) begin
                        c_ld[8*b +: 8] = rm[int'(c_addr) + b];
                        if (c_we) rm[int'(c_addr) + b] = c_wdata[8*b +: 8];
                    end
                end
                lat_at = k;
                free_at = k + 3;
            end
            eg = (lat_at == k);
            ed = (lat_at + 1 == k);
            oh = cp ? 2'b10 : 2'b01;
            if (ed) em_rd[cp] = !c_ok ? 64'd0 : (c_we ? em_rd[cp] : c_ld);
            chk("rnd_ctl", ctl(), ectl(eg ? oh : 2'b00, ed ? oh : 2'b00, (ed && !c_ok) ? oh : 2'b00,
                                      eg && c_ok && !c_we, eg && c_ok && c_we));
            chk("rnd_maddr", mem_addr, (eg && c_ok) ? c_addr : 64'd0);
            chk("rnd_mwdata", mem_wdata, (eg && c_ok) ? c_wdata : 64'd0);
            chk("rnd_rdata0", r0_rdata, em_rd[0]);
            chk("rnd_rdata1", r1_rdata, em_rd[1]);
            for (int p = 0; p < 2; p++) begin
                if (ed && int'(cp) == p) begin
                    if ($urandom % 2 == 0) new_op(p);
                    else a_req[p] = 1'b0;
                end else if (!a_req[p] && ($urandom % 3 == 0)) begin
                    new_op(p);
                end
                drive(1'(p), a_req[p], a_we[p], a_addr[p], a_wdata[p]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
